// File: rtl/bp_fe_queue_roll_ctrl.sv
// bp_fe_queue_roll_ctrl
// Sequencer for the BE-side rollable FE queue. Counts issued-but-uncommitted
// entries and turns commit / replay / redirect events into the queue's
// single-cycle dequeue, roll and clear strobes.
//
// Strobe semantics: deq_v_o, roll_v_o and clr_v_o are one-cycle pulses with no
// back-pressure; the queue must act on each in the cycle it is high.
// issue_yumi_i is only legal while issue_hold_o is low. Replay and flush
// requests are latched as pending and serviced in order roll, then clear.
module bp_fe_queue_roll_ctrl #(
   parameter int els_p     = 16,
   parameter int holdoff_p = 1
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic                       issue_yumi_i,
   input  logic                       commit_v_i,
   input  logic                       replay_v_i,
   input  logic                       flush_v_i,
   output logic                       deq_v_o,
   output logic                       roll_v_o,
   output logic                       clr_v_o,
   output logic                       issue_hold_o,
   output logic                       busy_o,
   output logic [$clog2(els_p+1)-1:0] inflight_o,
   output logic                       error_o
);

   localparam int cnt_w = $clog2(els_p+1);
   localparam logic [cnt_w-1:0] els_c = cnt_w'(els_p);
   localparam logic [2:0] hold_init = (holdoff_p > 0) ? 3'(holdoff_p - 1) : 3'd0;

   typedef enum logic [1:0] {RUN, ROLL, CLEAR, HOLD} state_e;

   state_e           state_r, state_n;
   logic             rp_pend_r, fl_pend_r, rp_pend_n, fl_pend_n;
   logic             hold_owed_r, hold_owed_n;
   logic [2:0]       hold_cnt_r, hold_cnt_n;
   logic [cnt_w-1:0] inflight_r, inflight_n;
   logic             error_r, error_n;
   logic             full, inc_ovf;

   // Strobes and hold are decodes of the registered state only.
   assign roll_v_o     = (state_r == ROLL);
   assign clr_v_o      = (state_r == CLEAR);
   assign issue_hold_o = (state_r == ROLL) || (state_r == HOLD);
   assign busy_o       = rp_pend_r | fl_pend_r | (state_r != RUN);
   assign inflight_o   = inflight_r;
   assign error_o      = error_r;

   // Dequeue follows commit with zero latency, gated so the count never underflows.
   assign deq_v_o = commit_v_i & (inflight_r != '0);
   assign full    = (inflight_r == els_c);
   assign inc_ovf = issue_yumi_i & ~deq_v_o & full;

   // Pending requests: a strobe clears its bit, a same-cycle request re-sets it.
   always_comb begin
      rp_pend_n = (rp_pend_r & (state_r != ROLL))  | replay_v_i;
      fl_pend_n = (fl_pend_r & (state_r != CLEAR)) | flush_v_i;
   end

   // Next-state selection; roll always takes priority over clear.
   always_comb begin
      state_n     = state_r;
      hold_cnt_n  = hold_cnt_r;
      hold_owed_n = hold_owed_r;
      unique case (state_r)
         RUN: begin
            if (rp_pend_n)      state_n = ROLL;
            else if (fl_pend_n) state_n = CLEAR;
         end
         ROLL: begin
            if (fl_pend_n) begin
               state_n     = CLEAR;
               hold_owed_n = (holdoff_p > 0);
            end else if (holdoff_p > 0) begin
               state_n    = HOLD;
               hold_cnt_n = hold_init;
            end else begin
               state_n = RUN;
            end
         end
         CLEAR: begin
            hold_owed_n = 1'b0;
            if (rp_pend_n) begin
               state_n = ROLL;
            end else if (hold_owed_r) begin
               // A roll that was followed by a clear still owes its issue holdoff.
               state_n    = HOLD;
               hold_cnt_n = hold_init;
            end else begin
               state_n = RUN;
            end
         end
         HOLD: begin
            if (hold_cnt_r != 3'd0) begin
               hold_cnt_n = hold_cnt_r - 3'd1;
            end else if (rp_pend_n) begin
               state_n = ROLL;
            end else if (fl_pend_n) begin
               state_n = CLEAR;
            end else begin
               state_n = RUN;
            end
         end
         default: state_n = RUN;
      endcase
   end

   // In-flight count: a roll rewinds to the checkpoint, otherwise issue minus dequeue, saturating.
   always_comb begin
      inflight_n = inflight_r;
      if (state_r == ROLL)                             inflight_n = '0;
      else if (issue_yumi_i && !deq_v_o && !full)      inflight_n = inflight_r + 1'b1;
      else if (!issue_yumi_i && deq_v_o)               inflight_n = inflight_r - 1'b1;
      error_n = error_r
              | (commit_v_i & (inflight_r == '0))
              | (issue_yumi_i & issue_hold_o)
              | inc_ovf;
   end

   // State, pending and counter registers with asynchronous reset.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_r     <= RUN;
         rp_pend_r   <= 1'b0;
         fl_pend_r   <= 1'b0;
         hold_owed_r <= 1'b0;
         hold_cnt_r  <= 3'd0;
         inflight_r  <= '0;
         error_r     <= 1'b0;
      end else begin
         state_r     <= state_n;
         rp_pend_r   <= rp_pend_n;
         fl_pend_r   <= fl_pend_n;
         hold_owed_r <= hold_owed_n;
         hold_cnt_r  <= hold_cnt_n;
         inflight_r  <= inflight_n;
         error_r     <= error_n;
      end
   end

endmodule

// File: tb/tb_bp_fe_queue_roll_ctrl.sv
// Directed testbench for bp_fe_queue_roll_ctrl (els_p=16, holdoff_p=1).
// Inputs change just after the falling edge; outputs are sampled 1 ns later,
// so each cyc() call observes exactly one clock cycle.
module tb_bp_fe_queue_roll_ctrl;

   logic       clk = 1'b0;
   logic       reset_i = 1'b0;
   logic       issue_yumi_i = 1'b0;
   logic       commit_v_i = 1'b0;
   logic       replay_v_i = 1'b0;
   logic       flush_v_i = 1'b0;
   logic       deq_v_o, roll_v_o, clr_v_o, issue_hold_o, busy_o, error_o;
   logic [4:0] inflight_o;

   int n_checks = 0;
   int n_errors = 0;

   bp_fe_queue_roll_ctrl #(.els_p(16), .holdoff_p(1)) dut (
      .clk_i(clk), .reset_i(reset_i),
      .issue_yumi_i(issue_yumi_i), .commit_v_i(commit_v_i),
      .replay_v_i(replay_v_i), .flush_v_i(flush_v_i),
      .deq_v_o(deq_v_o), .roll_v_o(roll_v_o), .clr_v_o(clr_v_o),
      .issue_hold_o(issue_hold_o), .busy_o(busy_o),
      .inflight_o(inflight_o), .error_o(error_o)
   );

   always #5 clk = ~clk;

   // ---------------- driver tasks ----------------
   task automatic cyc(input logic is, input logic cm, input logic rp, input logic fl);
      @(negedge clk);
      issue_yumi_i = is;
      commit_v_i   = cm;
      replay_v_i   = rp;
      flush_v_i    = fl;
      #1;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset_i = 1'b1;
      issue_yumi_i = 1'b0; commit_v_i = 1'b0; replay_v_i = 1'b0; flush_v_i = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset_i = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      apply_reset();
      cyc(0, 0, 0, 0);
      n_checks++;
      if ({deq_v_o, roll_v_o, clr_v_o, issue_hold_o, busy_o, error_o} !== 6'b0) begin
         n_errors++;
         $display("FAIL reset_flags: got %b expected 000000",
                  {deq_v_o, roll_v_o, clr_v_o, issue_hold_o, busy_o, error_o});
      end
      n_checks++;
      if (inflight_o !== 5'd0) begin
         n_errors++; $display("FAIL reset_inflight: got %0d expected 0", inflight_o);
      end
   endtask

   task automatic test_accounting();
      int pulses = 0;
      logic strobe_seen = 1'b0;
      apply_reset();
      for (int i = 0; i < 5; i++) begin
         cyc(1, 0, 0, 0);
         n_checks++;
         if (deq_v_o !== 1'b0) begin
            n_errors++; $display("FAIL acct_issue_deq: got %b expected 0", deq_v_o);
         end
         strobe_seen = strobe_seen | roll_v_o | clr_v_o;
      end
      for (int i = 0; i < 3; i++) begin
         cyc(0, 1, 0, 0);
         n_checks++;
         if (deq_v_o !== 1'b1) begin
            n_errors++; $display("FAIL acct_commit_deq: got %b expected 1", deq_v_o);
         end
         if (deq_v_o === 1'b1) pulses++;
         strobe_seen = strobe_seen | roll_v_o | clr_v_o;
      end
      cyc(0, 0, 0, 0);
      n_checks++;
      if (inflight_o !== 5'd2) begin
         n_errors++; $display("FAIL acct_inflight: got %0d expected 2", inflight_o);
      end
      n_checks++;
      if (pulses != 3 || deq_v_o !== 1'b0) begin
         n_errors++; $display("FAIL acct_deq_pulses: got %0d (deq now %b) expected 3 (deq 0)", pulses, deq_v_o);
      end
      n_checks++;
      if (strobe_seen !== 1'b0 || error_o !== 1'b0) begin
         n_errors++; $display("FAIL acct_no_strobe: strobe %b error %b expected 0 0", strobe_seen, error_o);
      end
   endtask

   task automatic test_replay();
      apply_reset();
      for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0);
      cyc(0, 0, 1, 0);                    // T
      n_checks++;
      if (roll_v_o !== 1'b0 || inflight_o !== 5'd4) begin
         n_errors++; $display("FAIL replay_T: roll %b inflight %0d expected 0 4", roll_v_o, inflight_o);
      end
      cyc(0, 0, 0, 0);                    // T+1
      n_checks++;
      if (roll_v_o !== 1'b1 || issue_hold_o !== 1'b1 || clr_v_o !== 1'b0) begin
         n_errors++; $display("FAIL replay_T1: roll %b hold %b clr %b expected 1 1 0", roll_v_o, issue_hold_o, clr_v_o);
      end
      cyc(0, 0, 0, 0);                    // T+2
      n_checks++;
      if (roll_v_o !== 1'b0 || issue_hold_o !== 1'b1 || inflight_o !== 5'd0 || busy_o !== 1'b1) begin
         n_errors++; $display("FAIL replay_T2: roll %b hold %b inflight %0d busy %b expected 0 1 0 1",
                              roll_v_o, issue_hold_o, inflight_o, busy_o);
      end
      cyc(0, 0, 0, 0);                    // T+3
      n_checks++;
      if (busy_o !== 1'b0 || issue_hold_o !== 1'b0 || roll_v_o !== 1'b0) begin
         n_errors++; $display("FAIL replay_T3: busy %b hold %b roll %b expected 0 0 0", busy_o, issue_hold_o, roll_v_o);
      end
   endtask

   task automatic test_replay_flush();
      apply_reset();
      cyc(1, 0, 0, 0);
      cyc(1, 0, 0, 0);
      cyc(0, 0, 1, 1);                    // T
      cyc(0, 1, 0, 0);                    // T+1: commit while rolling
      n_checks++;
      if (roll_v_o !== 1'b1 || clr_v_o !== 1'b0 || deq_v_o !== 1'b1) begin
         n_errors++; $display("FAIL rf_T1: roll %b clr %b deq %b expected 1 0 1", roll_v_o, clr_v_o, deq_v_o);
      end
      cyc(0, 0, 0, 0);                    // T+2
      n_checks++;
      if (roll_v_o !== 1'b0 || clr_v_o !== 1'b1 || inflight_o !== 5'd0 || issue_hold_o !== 1'b0) begin
         n_errors++; $display("FAIL rf_T2: roll %b clr %b inflight %0d hold %b expected 0 1 0 0",
                              roll_v_o, clr_v_o, inflight_o, issue_hold_o);
      end
      cyc(0, 0, 0, 0);                    // T+3: holdoff after the clear
      n_checks++;
      if (issue_hold_o !== 1'b1 || clr_v_o !== 1'b0 || roll_v_o !== 1'b0 || busy_o !== 1'b1) begin
         n_errors++; $display("FAIL rf_T3: hold %b clr %b roll %b busy %b expected 1 0 0 1",
                              issue_hold_o, clr_v_o, roll_v_o, busy_o);
      end
      cyc(0, 0, 0, 0);                    // T+4
      n_checks++;
      if (busy_o !== 1'b0 || issue_hold_o !== 1'b0 || error_o !== 1'b0) begin
         n_errors++; $display("FAIL rf_T4: busy %b hold %b error %b expected 0 0 0", busy_o, issue_hold_o, error_o);
      end
   endtask

   task automatic test_flush_issue();
      apply_reset();
      cyc(0, 0, 0, 1);                    // T
      n_checks++;
      if (clr_v_o !== 1'b0) begin
         n_errors++; $display("FAIL fi_T: clr %b expected 0", clr_v_o);
      end
      cyc(1, 0, 0, 0);                    // T+1: issue during clear
      n_checks++;
      if (clr_v_o !== 1'b1 || issue_hold_o !== 1'b0 || roll_v_o !== 1'b0) begin
         n_errors++; $display("FAIL fi_T1: clr %b hold %b roll %b expected 1 0 0", clr_v_o, issue_hold_o, roll_v_o);
      end
      cyc(0, 0, 0, 0);                    // T+2
      n_checks++;
      if (inflight_o !== 5'd1 || clr_v_o !== 1'b0 || busy_o !== 1'b0 || error_o !== 1'b0) begin
         n_errors++; $display("FAIL fi_T2: inflight %0d clr %b busy %b error %b expected 1 0 0 0",
                              inflight_o, clr_v_o, busy_o, error_o);
      end
   endtask

   task automatic test_errors();
      // commit with nothing in flight
      apply_reset();
      cyc(0, 1, 0, 0);
      n_checks++;
      if (deq_v_o !== 1'b0 || error_o !== 1'b0) begin
         n_errors++; $display("FAIL err_empty_commit: deq %b error %b expected 0 0", deq_v_o, error_o);
      end
      cyc(0, 0, 0, 0);
      n_checks++;
      if (error_o !== 1'b1 || inflight_o !== 5'd0) begin
         n_errors++; $display("FAIL err_empty_set: error %b inflight %0d expected 1 0", error_o, inflight_o);
      end
      cyc(1, 0, 0, 0);
      cyc(0, 0, 0, 0);
      n_checks++;
      if (error_o !== 1'b1) begin
         n_errors++; $display("FAIL err_sticky: error %b expected 1", error_o);
      end
      // issue during HOLD
      apply_reset();
      cyc(1, 0, 0, 0);
      cyc(0, 0, 1, 0);                    // T
      cyc(0, 0, 0, 0);                    // T+1 ROLL
      cyc(1, 0, 0, 0);                    // T+2 HOLD with illegal issue
      n_checks++;
      if (issue_hold_o !== 1'b1 || error_o !== 1'b0) begin
         n_errors++; $display("FAIL err_hold_pre: hold %b error %b expected 1 0", issue_hold_o, error_o);
      end
      cyc(0, 0, 0, 0);
      n_checks++;
      if (error_o !== 1'b1) begin
         n_errors++; $display("FAIL err_hold_issue: error %b expected 1", error_o);
      end
      // saturation
      apply_reset();
      for (int i = 0; i < 16; i++) cyc(1, 0, 0, 0);
      cyc(1, 0, 0, 0);                    // 17th issue
      n_checks++;
      if (inflight_o !== 5'd16 || error_o !== 1'b0) begin
         n_errors++; $display("FAIL err_full: inflight %0d error %b expected 16 0", inflight_o, error_o);
      end
      cyc(0, 0, 0, 0);
      n_checks++;
      if (inflight_o !== 5'd16 || error_o !== 1'b1) begin
         n_errors++; $display("FAIL err_saturate: inflight %0d error %b expected 16 1", inflight_o, error_o);
      end
   endtask

   task automatic test_async_reset();
      logic strobe_seen = 1'b0;
      apply_reset();
      cyc(1, 0, 0, 0);
      cyc(1, 0, 0, 0);
      cyc(0, 0, 1, 0);                    // T
      cyc(0, 0, 0, 0);                    // T+1 ROLL
      cyc(0, 0, 0, 1);                    // T+2 HOLD, flush arrives
      n_checks++;
      if (issue_hold_o !== 1'b1 || busy_o !== 1'b1) begin
         n_errors++; $display("FAIL ar_pre: hold %b busy %b expected 1 1", issue_hold_o, busy_o);
      end
      reset_i = 1'b1;                     // between clock edges
      #1;
      n_checks++;
      if ({deq_v_o, roll_v_o, clr_v_o, issue_hold_o, busy_o, error_o} !== 6'b0 || inflight_o !== 5'd0) begin
         n_errors++; $display("FAIL ar_immediate: flags %b inflight %0d expected 000000 0",
                              {deq_v_o, roll_v_o, clr_v_o, issue_hold_o, busy_o, error_o}, inflight_o);
      end
      flush_v_i = 1'b0;
      @(negedge clk);
      reset_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cyc(0, 0, 0, 0);
         strobe_seen = strobe_seen | roll_v_o | clr_v_o | busy_o;
      end
      n_checks++;
      if (strobe_seen !== 1'b0) begin
         n_errors++; $display("FAIL ar_no_strobe: strobe/busy seen %b expected 0", strobe_seen);
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_accounting();
      test_replay();
      test_replay_flush();
      test_flush_issue();
      test_errors();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
